cp0_unit: RTL and testbench

- Coprocessor 0 for the P8 five-stage MIPS pipeline; sits at the M stage and arbitrates exceptions and interrupts.
- Consumes the exception code, branch-delay flag and PC carried down the pipeline registers, plus external hardware interrupts.
- Produces Req, EPCOut and mfc0 read data. Req and EPCOut drive the flush/redirect inputs of every pipeline register.
- Holds SR(12), Cause(13), EPC(14) and PRId(15).

---
 rtl/cp0_pkg.sv | 65 ++++++
 rtl/cp0_if.sv | 26 ++
 rtl/cp0_timer.sv | 39 +++
 rtl/cp0_unit.sv | 97 +++++++++
 tb/tb_cp0_unit.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/cp0_pkg.sv
// Shared definitions for the CP0 unit: register numbers, field layout,
// exception codes and packing helpers for SR/Cause reads.
package cp0_pkg;

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_SR      = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;
  localparam logic [4:0] REG_PRID    = 5'd15;

  localparam logic [31:0] PRID_DEFAULT = 32'h2022_0808;
  // Handler entry; consumed by the F-stage PC mux, not by CP0 itself
  localparam logic [31:0] EXC_VECTOR   = 32'h0000_4180;

  localparam int SR_IE_BIT     = 0;
  localparam int SR_EXL_BIT    = 1;
  localparam int SR_IM_LSB     = 10;
  localparam int SR_IM_MSB     = 15;
  localparam int CAUSE_EXC_LSB = 2;
  localparam int CAUSE_EXC_MSB = 6;
  localparam int CAUSE_IP_LSB  = 10;
  localparam int CAUSE_IP_MSB  = 15;
  localparam int CAUSE_BD_BIT  = 31;

  typedef enum logic [4:0] {
    EXC_INT     = 5'd0,
    EXC_ADEL    = 5'd4,
    EXC_ADES    = 5'd5,
    EXC_SYSCALL = 5'd8,
    EXC_RI      = 5'd10,
    EXC_OV      = 5'd12
  } exc_code_e;

  typedef struct packed {
    logic [5:0] im;
    logic       exl;
    logic       ie;
  } sr_t;

  typedef struct packed {
    logic       bd;
    logic [5:0] ip;
    logic [4:0] exc_code;
  } cause_t;

  function automatic logic [31:0] pack_sr(input sr_t s);
    logic [31:0] v;
    v = '0;
    v[SR_IM_MSB:SR_IM_LSB] = s.im;
    v[SR_EXL_BIT]          = s.exl;
    v[SR_IE_BIT]           = s.ie;
    return v;
  endfunction

  function automatic logic [31:0] pack_cause(input cause_t c);
    logic [31:0] v;
    v = '0;
    v[CAUSE_BD_BIT]                = c.bd;
    v[CAUSE_IP_MSB:CAUSE_IP_LSB]   = c.ip;
    v[CAUSE_EXC_MSB:CAUSE_EXC_LSB] = c.exc_code;
    return v;
  endfunction

endpackage

// File: rtl/cp0_if.sv
// M-stage bus between the pipeline and CP0: mfc0/mtc0 access, exception
// inputs, interrupt lines, and the flush/redirect outputs.
interface cp0_if;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic        We;
  logic [31:0] VPC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic [31:0] DOut;
  logic [31:0] EPCOut;
  logic        Req;

  modport master (
    output A1, A2, DIn, We, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
    input  DOut, EPCOut, Req
  );

  modport slave (
    input  A1, A2, DIn, We, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
    output DOut, EPCOut, Req
  );
endinterface

// File: rtl/cp0_timer.sv
// Count/Compare timer. Count free-runs and wraps; irq is raised from the
// cycle Count matches Compare until software rewrites Compare.
module cp0_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        irq
);
  logic [31:0] count_reg;
  logic [31:0] compare_reg;
  logic        pending_reg;
  logic        hit;

  assign hit     = (count_reg == compare_reg);
  assign count   = count_reg;
  assign compare = compare_reg;
  // The match cycle itself already signals, the register holds it afterwards
  assign irq     = pending_reg | hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg   <= '0;
      compare_reg <= '0;
      pending_reg <= 1'b0;
    end else begin
      count_reg <= count_we ? wdata : count_reg + 32'd1;
      if (compare_we) begin
        compare_reg <= wdata;
        pending_reg <= 1'b0;
      end else if (hit) begin
        pending_reg <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/cp0_unit.sv
// Coprocessor 0 at the M stage: SR/Cause/EPC/PRId, exception and interrupt
// arbitration. Define CP0_TIMER_EN to add the Count/Compare timer on HWInt[5].
module cp0_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID = PRID_DEFAULT
) (
  input  logic   clk,
  input  logic   reset,
  cp0_if.slave   bus
);
  sr_t         sr_reg;
  cause_t      cause_reg;
  logic [31:0] epc_reg;

  logic [5:0]  hw_int_eff;
  logic        timer_irq;
  logic [31:0] count_val;
  logic [31:0] compare_val;
  logic        int_req;
  logic        exc_req;
  logic        req;
  logic        sr_we;
  logic        epc_fwd;
  logic [31:0] epc_target;
  logic [31:0] dout;

`ifdef CP0_TIMER_EN
  cp0_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .count_we   (bus.We && (bus.A2 == REG_COUNT) && !req),
    .compare_we (bus.We && (bus.A2 == REG_COMPARE) && !req),
    .wdata      (bus.DIn),
    .count      (count_val),
    .compare    (compare_val),
    .irq        (timer_irq)
  );
`else
  assign timer_irq   = 1'b0;
  assign count_val   = '0;
  assign compare_val = '0;
`endif

  assign hw_int_eff = bus.HWInt | {timer_irq, 5'b0};
  assign int_req    = (|(hw_int_eff & sr_reg.im)) & sr_reg.ie & !sr_reg.exl;
  assign exc_req    = (bus.ExcCodeIn != 5'd0) & !sr_reg.exl;
  // Req is also a flush control, so keep it quiet while reset is held
  assign req        = !reset && (int_req || exc_req);

  assign sr_we      = bus.We && (bus.A2 == REG_SR);
  assign epc_fwd    = bus.We && (bus.A2 == REG_EPC);
  assign epc_target = (bus.BDIn ? (bus.VPC - 32'd4) : bus.VPC) & 32'hFFFF_FFFC;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_reg    <= '0;
      cause_reg <= '0;
      epc_reg   <= '0;
    end else begin
      cause_reg.ip <= hw_int_eff;
      if (req) begin
        sr_reg.exl         <= 1'b1;
        cause_reg.bd       <= bus.BDIn;
        cause_reg.exc_code <= int_req ? EXC_INT : bus.ExcCodeIn;
        epc_reg            <= epc_target;
      end else begin
        if (sr_we) begin
          sr_reg.im  <= bus.DIn[SR_IM_MSB:SR_IM_LSB];
          sr_reg.exl <= bus.DIn[SR_EXL_BIT];
          sr_reg.ie  <= bus.DIn[SR_IE_BIT];
        end
        if (epc_fwd) epc_reg <= bus.DIn;
        // eret wins the EXL bit over a coincident mtc0 to SR
        if (bus.EXLClr) sr_reg.exl <= 1'b0;
      end
    end
  end

  always_comb begin
    dout = '0;
    case (bus.A1)
      REG_SR:      dout = pack_sr(sr_reg);
      REG_CAUSE:   dout = pack_cause(cause_reg);
      REG_EPC:     dout = epc_reg;
      REG_PRID:    dout = PRID;
      REG_COUNT:   dout = count_val;
      REG_COMPARE: dout = compare_val;
      default:     dout = '0;
    endcase
  end

  assign bus.DOut   = dout;
  assign bus.Req    = req;
  // Forwarding lets an eret directly behind mtc0 EPC return to the new value
  assign bus.EPCOut = reset ? 32'd0 : (epc_fwd ? bus.DIn : epc_reg);
endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit: reset, exceptions, delay slot, interrupt
// priority, mtc0/eret interaction, async reset, and the optional timer.
module tb_cp0_unit;
  import cp0_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  cp0_if bus ();

  cp0_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      $display("check %s ok value=%h", tag, obs);
    end else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    bus.A1 = a;
    #1;
    chk(tag, bus.DOut, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.A2 = 5'd0; bus.DIn = '0; bus.We = 1'b0; bus.VPC = '0; bus.BDIn = 1'b0;
    bus.ExcCodeIn = 5'd0; bus.EXLClr = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    idle();
    bus.A1 = 5'd0;
    bus.HWInt = 6'd0;
    reset = 1'b1;

    // Outputs while reset is held, with hostile inputs
    #3;
    bus.ExcCodeIn = 5'd12; bus.We = 1'b1; bus.A2 = 5'd14; bus.DIn = 32'h1234;
    bus.A1 = 5'd15;
    #1;
    chk("rst_req", {31'd0, bus.Req}, 32'd0);
    chk("rst_epcout", bus.EPCOut, 32'd0);
    chk("rst_prid", bus.DOut, 32'h2022_0808);
    idle();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    rd("prid", 5'd15, 32'h2022_0808);
    rd("sr_reset", 5'd12, 32'd0);
    rd("cause_reset", 5'd13, 32'd0);
    rd("epc_reset", 5'd14, 32'd0);
    chk("req_reset", {31'd0, bus.Req}, 32'd0);

`ifdef CP0_TIMER_EN
    bus.We = 1'b1; bus.A2 = 5'd11; bus.DIn = 32'd20; tick();
    bus.A2 = 5'd12; bus.DIn = 32'h0000_8001; tick();
    bus.A2 = 5'd9; bus.DIn = 32'd10; tick();
    idle();
    bus.A1 = 5'd9;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (bus.Req) break;
      tick();
    end
    chk("tmr_req", {31'd0, bus.Req}, 32'd1);
    chk("tmr_count_at_req", bus.DOut, 32'd20);
    tick();
    rd("tmr_cause", 5'd13, 32'h0000_8000);
    bus.We = 1'b1; bus.A2 = 5'd11; bus.DIn = 32'd1000; tick();
    idle(); bus.EXLClr = 1'b1; tick();
    idle(); #1;
    chk("tmr_cleared", {31'd0, bus.Req}, 32'd0);
    bus.We = 1'b1; bus.A2 = 5'd9; bus.DIn = 32'hFFFF_FFFF; tick();
    idle();
    rd("tmr_max", 5'd9, 32'hFFFF_FFFF);
    tick();
    rd("tmr_wrap", 5'd9, 32'd0);
    bus.We = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'd0; tick();
    idle(); tick();
`endif

    // Exception outside a delay slot; the coincident mtc0 is dropped
    bus.ExcCodeIn = 5'd12; bus.VPC = 32'h3010; bus.BDIn = 1'b0;
    bus.We = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'hFFFF_FFFF;
    #1;
    chk("exc_req", {31'd0, bus.Req}, 32'd1);
    tick();
    idle();
    rd("exc_epc", 5'd14, 32'h0000_3010);
    rd("exc_cause", 5'd13, 32'h0000_0030);
    rd("exc_sr", 5'd12, 32'h0000_0002);
    bus.ExcCodeIn = 5'd4;
    #1;
    chk("exc_masked_by_exl", {31'd0, bus.Req}, 32'd0);
    idle(); bus.EXLClr = 1'b1; tick();
    idle();
    rd("eret_sr", 5'd12, 32'd0);

    // Exception in a branch delay slot
    bus.ExcCodeIn = 5'd10; bus.BDIn = 1'b1; bus.VPC = 32'h3024;
    #1;
    chk("bd_req", {31'd0, bus.Req}, 32'd1);
    tick();
    idle();
    rd("bd_epc", 5'd14, 32'h0000_3020);
    rd("bd_cause", 5'd13, 32'h8000_0028);
    chk("bd_epcout", bus.EPCOut, 32'h0000_3020);
    bus.EXLClr = 1'b1; tick();

    // Misaligned VPC is forced to a word boundary
    idle(); bus.ExcCodeIn = 5'd4; bus.VPC = 32'h3013; tick();
    idle();
    rd("align_epc", 5'd14, 32'h0000_3010);
    rd("align_cause", 5'd13, 32'h0000_0010);
    bus.EXLClr = 1'b1; tick();

    // Interrupt beats a simultaneous exception
    idle(); bus.We = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0401; tick();
    idle();
    rd("sr_write", 5'd12, 32'h0000_0401);
    bus.HWInt = 6'b000001; bus.ExcCodeIn = 5'd8; bus.VPC = 32'h4000;
    #1;
    chk("int_req", {31'd0, bus.Req}, 32'd1);
    tick();
    idle();
    rd("int_cause", 5'd13, 32'h0000_0400);
    rd("int_epc", 5'd14, 32'h0000_4000);
    rd("int_sr", 5'd12, 32'h0000_0403);
    bus.HWInt = 6'd0; bus.EXLClr = 1'b1; tick();
    idle(); bus.We = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0400; tick();
    idle(); bus.HWInt = 6'b000001;
    #1;
    chk("int_ie_off", {31'd0, bus.Req}, 32'd0);
    bus.HWInt = 6'b100000; tick();
    rd("ip_sample", 5'd13, 32'h0000_8000);
    bus.HWInt = 6'd0;

    // mtc0 EPC forwarded to a coincident eret
    bus.ExcCodeIn = 5'd5; bus.VPC = 32'h5000; tick();
    idle(); bus.We = 1'b1; bus.A2 = 5'd14; bus.DIn = 32'h3400; bus.EXLClr = 1'b1;
    #1;
    chk("epc_forward", bus.EPCOut, 32'h0000_3400);
    tick();
    idle();
    rd("eret_exl_clear", 5'd12, 32'h0000_0400);
    rd("epc_written", 5'd14, 32'h0000_3400);

    // EXLClr overrides the EXL bit of a coincident SR write
    bus.ExcCodeIn = 5'd5; tick();
    idle(); bus.We = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0403; bus.EXLClr = 1'b1; tick();
    idle();
    rd("sr_exlclr_wins", 5'd12, 32'h0000_0401);

    // Read-only and unmapped numbers ignore writes
    bus.We = 1'b1; bus.A2 = 5'd13; bus.DIn = 32'hFFFF_FFFF; tick();
    bus.A2 = 5'd15; tick();
    idle();
    rd("cause_ro", 5'd13, 32'h0000_0014);
    rd("prid_ro", 5'd15, 32'h2022_0808);
`ifndef CP0_TIMER_EN
    bus.We = 1'b1; bus.A2 = 5'd9; bus.DIn = 32'd5; tick();
    bus.A2 = 5'd11; tick();
    idle();
    rd("count_absent", 5'd9, 32'd0);
    rd("compare_absent", 5'd11, 32'd0);
`endif

    // Asynchronous reset mid-handler
    bus.ExcCodeIn = 5'd4; bus.VPC = 32'h6000; tick();
    idle();
    #1;
    reset = 1'b1;
    rd("areset_sr", 5'd12, 32'd0);
    rd("areset_cause", 5'd13, 32'd0);
    rd("areset_epc", 5'd14, 32'd0);
    chk("areset_epcout", bus.EPCOut, 32'd0);
    tick();
    reset = 1'b0;
    rd("post_reset_sr", 5'd12, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
